// File: rtl/key_period_pkg.sv
// Shared constants for key_period_gen: lowest-octave period table (A0..G#1, Q11.4 samples
// at 48 kHz), default key for out-of-range requests, and the FSM state encoding.
package key_period_pkg;

   localparam logic [7:0] KEY_DEFAULT = 8'h45;
   localparam int         SEMIS       = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DIV,
      ST_LOOK,
      ST_BEND,
      ST_CALC,
      ST_OUT
   } state_t;

   // Period of semitone idx within the lowest octave; higher octaves are derived by shifting.
   function automatic logic [15:0] table_entry(input logic [3:0] idx);
      logic [15:0] val;
      case (idx)
         4'd0:    val = 16'd27927;
         4'd1:    val = 16'd26360;
         4'd2:    val = 16'd24880;
         4'd3:    val = 16'd23484;
         4'd4:    val = 16'd22166;
         4'd5:    val = 16'd20922;
         4'd6:    val = 16'd19748;
         4'd7:    val = 16'd18639;
         4'd8:    val = 16'd17593;
         4'd9:    val = 16'd16606;
         4'd10:   val = 16'd15674;
         4'd11:   val = 16'd14794;
         default: val = 16'd0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/key_period_gen_if.sv
// Request/result handshake bundle between the MIDI parser, key_period_gen and the voice allocator.
interface key_period_gen_if #(
   parameter int LEN_W   = 11,
   parameter int FRAC_W  = 4,
   parameter int VOICE_W = 2
);
   logic                      in_valid;
   logic                      in_ready;
   logic [7:0]                in_key;
   logic [7:0]                in_bend;
   logic [VOICE_W-1:0]        in_voice;
   logic                      out_valid;
   logic                      out_ready;
   logic [LEN_W+FRAC_W-1:0]   out_period;
   logic [VOICE_W-1:0]        out_voice;
   logic                      out_err;

   modport master (
      output in_valid, in_key, in_bend, in_voice, out_ready,
      input  in_ready, out_valid, out_period, out_voice, out_err
   );

   modport slave (
      input  in_valid, in_key, in_bend, in_voice, out_ready,
      output in_ready, out_valid, out_period, out_voice, out_err
   );
endinterface

// File: rtl/key_octave_div.sv
// Iterative divide-by-12: splits a key offset into octave and semitone, one subtraction per cycle.
module key_octave_div
   import key_period_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] val,
   output logic [3:0] rem,
   output logic [2:0] oct,
   output logic       done
);

   logic       busy_reg;
   logic [6:0] rem_reg;
   logic [2:0] oct_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_reg <= 1'b0;
         rem_reg  <= '0;
         oct_reg  <= '0;
      end else if (start) begin
         busy_reg <= 1'b1;
         rem_reg  <= val;
         oct_reg  <= '0;
      end else if (busy_reg) begin
         if (rem_reg >= 7'(SEMIS)) begin
            rem_reg <= rem_reg - 7'(SEMIS);
            oct_reg <= oct_reg + 3'd1;
         end else begin
            busy_reg <= 1'b0;
         end
      end
   end

   // Results stay held after done until the next start.
   assign done = busy_reg && (rem_reg < 7'(SEMIS));
   assign rem  = rem_reg[3:0];
   assign oct  = oct_reg;

endmodule

// File: rtl/key_period_gen.sv
// MIDI key (+ optional pitch bend) to delay-line period converter, one request in flight.
// Define PITCH_BEND_EN to add the BEND state and neighbour-semitone interpolation.
module key_period_gen
   import key_period_pkg::*;
#(
   parameter int         LEN_W   = 11,
   parameter int         FRAC_W  = 4,
   parameter int         VOICE_W = 2,
   parameter logic [7:0] KEY_MIN = 8'h15,
   parameter logic [7:0] KEY_MAX = 8'h6C
) (
   input logic             clk,
   input logic             rst,
   key_period_gen_if.slave bus
);

   localparam int PERIOD_W = LEN_W + FRAC_W;

   state_t               state_reg;
   state_t               state_next;
   logic                 in_ready;
   logic                 out_valid;
   logic                 accept;
   logic                 key_ok;
   logic [7:0]           key_eff;
   logic [3:0]           div_rem;
   logic [2:0]           div_oct;
   logic                 div_done;
   logic [VOICE_W-1:0]   voice_reg;
   logic                 err_reg;
   logic [15:0]          base_reg;
   logic [6:0]           rnd_add;
   logic [16:0]          rnd_sum;
   logic [PERIOD_W-1:0]  period_reg;
   logic [VOICE_W-1:0]   out_voice_reg;
   logic                 out_err_reg;

   assign accept  = bus.in_valid && in_ready;
   assign key_ok  = (bus.in_key >= KEY_MIN) && (bus.in_key <= KEY_MAX);
   assign key_eff = key_ok ? bus.in_key : KEY_DEFAULT;

   key_octave_div u_div (
      .clk   (clk),
      .rst   (rst),
      .start (accept),
      .val   (7'(key_eff - KEY_MIN)),
      .rem   (div_rem),
      .oct   (div_oct),
      .done  (div_done)
   );

`ifdef PITCH_BEND_EN
   logic [7:0]         bend_reg;
   logic [15:0]        nb_reg;
   logic [15:0]        nb_sel;
   logic [7:0]         bend_mag;
   logic signed [16:0] diff;
   logic signed [24:0] prod;

   // Positive bend interpolates toward the next semitone up (shorter period), negative toward the one below.
   always_comb begin
      nb_sel = '0;
      if (!bend_reg[7]) begin
         nb_sel = (div_rem == 4'd11) ? (table_entry(4'd0) >> 1) : table_entry(div_rem + 4'd1);
      end else begin
         nb_sel = (div_rem == 4'd0) ? (table_entry(4'd11) << 1) : table_entry(div_rem - 4'd1);
      end
   end

   assign bend_mag = bend_reg[7] ? (~bend_reg + 8'd1) : bend_reg;
   assign diff     = $signed({1'b0, nb_reg}) - $signed({1'b0, base_reg});
   assign prod     = 25'(diff) * 25'($signed({1'b0, bend_mag}));
`else
   // Bend input has no effect in this build.
   logic unused_bend;
   assign unused_bend = ^bus.in_bend;
`endif

   assign rnd_add = (div_oct == 3'd0) ? 7'd0 : (7'd1 << (div_oct - 3'd1));
   assign rnd_sum = {1'b0, base_reg} + {10'd0, rnd_add};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (bus.in_valid) state_next = ST_DIV;
         ST_DIV:  if (div_done)     state_next = ST_LOOK;
`ifdef PITCH_BEND_EN
         ST_LOOK: state_next = ST_BEND;
         ST_BEND: state_next = ST_CALC;
`else
         ST_LOOK: state_next = ST_CALC;
`endif
         ST_CALC: state_next = ST_OUT;
         ST_OUT:  if (bus.out_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      if (!rst && (state_reg == ST_IDLE)) in_ready = 1'b1;
      if (state_reg == ST_OUT) out_valid = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         voice_reg     <= '0;
         err_reg       <= 1'b0;
         base_reg      <= '0;
         period_reg    <= '0;
         out_voice_reg <= '0;
         out_err_reg   <= 1'b0;
`ifdef PITCH_BEND_EN
         bend_reg      <= '0;
         nb_reg        <= '0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  voice_reg <= bus.in_voice;
                  err_reg   <= !key_ok;
`ifdef PITCH_BEND_EN
                  bend_reg  <= key_ok ? bus.in_bend : 8'd0;
`endif
               end
            end
            ST_LOOK: begin
               base_reg <= table_entry(div_rem);
`ifdef PITCH_BEND_EN
               nb_reg   <= nb_sel;
`endif
            end
`ifdef PITCH_BEND_EN
            // Result always fits in 16 bits, so modular addition of the truncated delta is exact.
            ST_BEND: base_reg <= base_reg + 16'(prod >>> 7);
`endif
            ST_CALC: begin
               period_reg    <= PERIOD_W'(rnd_sum >> div_oct);
               out_voice_reg <= voice_reg;
               out_err_reg   <= err_reg;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid;
   assign bus.out_period = period_reg;
   assign bus.out_voice  = out_voice_reg;
   assign bus.out_err    = out_err_reg;

endmodule

// File: tb/tb_key_period_gen.sv
// Directed self-checking bench for key_period_gen; expected periods and latencies are hand-computed.
module tb_key_period_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

`ifdef PITCH_BEND_EN
   localparam int BL = 1;
`else
   localparam int BL = 0;
`endif

   key_period_gen_if bus ();

   key_period_gen dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; presents a request and releases it after the accept edge.
   task automatic send(input logic [7:0] key, input logic [7:0] bend, input logic [1:0] voice);
      bus.in_valid = 1'b1;
      bus.in_key   = key;
      bus.in_bend  = bend;
      bus.in_voice = voice;
      check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Latency counts edges from the accept edge (inclusive) to the edge raising out_valid.
   task automatic get_result(input string tag, input int period, input int err, input int voice,
                             input int lat);
      int cnt = 1;
      while (!bus.out_valid && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      $display("%s: period=%0d err=%0d voice=%0d latency=%0d", tag, bus.out_period, bus.out_err,
               bus.out_voice, cnt);
      check({tag, "_latency"}, 32'(cnt), 32'(lat));
      check({tag, "_period"}, 32'(bus.out_period), 32'(period));
      check({tag, "_err"}, 32'(bus.out_err), 32'(err));
      check({tag, "_voice"}, 32'(bus.out_voice), 32'(voice));
      check({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      if (bus.out_ready) begin
         @(negedge clk);
         check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
         check({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
      end
   endtask

   initial begin
      int seen;
      bus.in_valid  = 1'b0;
      bus.in_key    = 8'h00;
      bus.in_bend   = 8'h00;
      bus.in_voice  = 2'd0;
      bus.out_ready = 1'b1;

      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_period", 32'(bus.out_period), 32'd0);
      check("rst_out_voice", 32'(bus.out_voice), 32'd0);
      check("rst_out_err", 32'(bus.out_err), 32'd0);
      rst = 1'b0;
      #1;
      check("release_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);

      send(8'h15, 8'd0, 2'd1);  get_result("key15", 27927, 0, 1, 4 + BL);
      send(8'h45, 8'd0, 2'd0);  get_result("key45", 1745, 0, 0, 8 + BL);
      send(8'h5D, 8'd0, 2'd3);  get_result("key5D", 436, 0, 3, 10 + BL);
      send(8'h10, 8'd0, 2'd2);  get_result("key10_oor", 1745, 1, 2, 8 + BL);
      send(8'h6C, 8'd0, 2'd1);  get_result("key6C_max", 183, 0, 1, 11 + BL);
      send(8'h6D, 8'd0, 2'd0);  get_result("key6D_oor", 1745, 1, 0, 8 + BL);
      send(8'h14, 8'd0, 2'd3);  get_result("key14_oor", 1745, 1, 3, 8 + BL);
      send(8'h20, 8'd0, 2'd2);  get_result("key20_rem11", 14794, 0, 2, 4 + BL);
      send(8'h3C, 8'd0, 2'd1);  get_result("key3C", 2936, 0, 1, 7 + BL);

`ifdef PITCH_BEND_EN
      send(8'h45, 8'd127, 2'd1); get_result("bend45_p127", 1648, 0, 1, 9);
      send(8'h45, 8'd0, 2'd0);   get_result("bend45_zero", 1745, 0, 0, 9);
      send(8'h15, 8'h80, 2'd2);  get_result("bend15_m128", 29588, 0, 2, 5);
      send(8'h20, 8'd64, 2'd3);  get_result("bend20_p64", 14378, 0, 3, 5);
      send(8'h70, 8'd127, 2'd1); get_result("bend70_oor", 1745, 1, 1, 9);
`else
      send(8'h45, 8'd127, 2'd1); get_result("nobend45", 1745, 0, 1, 8);
      send(8'h70, 8'hFB, 2'd2);  get_result("nobend70_oor", 1745, 1, 2, 8);
`endif

      // Stall the output; a second request presented meanwhile must wait for the handshake.
      bus.out_ready = 1'b0;
      send(8'h15, 8'd0, 2'd3);
      get_result("stall", 27927, 0, 3, 4 + BL);
      bus.in_valid = 1'b1;
      bus.in_key   = 8'h5D;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", 32'(bus.out_valid), 32'd1);
         check("stall_period", 32'(bus.out_period), 32'd27927);
         check("stall_voice", 32'(bus.out_voice), 32'd3);
         check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("stall_release_valid", 32'(bus.out_valid), 32'd0);
      check("stall_release_in_ready", 32'(bus.in_ready), 32'd1);
      send(8'h45, 8'd0, 2'd1);
      get_result("after_stall", 1745, 0, 1, 8 + BL);

      // Abort a long request while it is still dividing.
      send(8'h6C, 8'd0, 2'd2);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_in_ready", 32'(bus.in_ready), 32'd0);
      check("abort_out_period", 32'(bus.out_period), 32'd0);
      check("abort_out_voice", 32'(bus.out_voice), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_release_in_ready", 32'(bus.in_ready), 32'd1);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      $display("abort: out_valid cycles after reset=%0d", seen);
      check("abort_no_out_valid", 32'(seen), 32'd0);
      send(8'h15, 8'd0, 2'd0);
      get_result("recover", 27927, 0, 0, 4 + BL);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
